ans_encoder: RTL and testbench
==============================

// Module: ans_encoder
// PURPOSE
//  rANS encoder producing the nibble stream ans_decoder consumes. Accepts symbols over a 4-phase handshake,
//  renormalises, and updates a STATE_WIDTH-bit coder state via a sequential divider. On in_last it flushes the
//  final state. Host reverses both symbol order (encode last-decoded first) and the emitted nibble stream.
// PARAMETERS (`define macros shared with ans_decoder)
//  SYM_WIDTH    4   symbol/nibble width
//  SYM_COUNT    16  alphabet size
//  CNT_WIDTH    8   per-symbol frequency width
//  STATE_WIDTH  16  coder state width; multiple of 4, >= CNT_WIDTH+2*SYM_WIDTH
// PORTS
//  clk                  in   1                        clock
//  rst                  in   1                        synchronous active-high reset
//  ena                  in   1                        advance enable; ena=0 freezes all registers
//  counts_unpacked      in   CNT_WIDTH*SYM_COUNT      f[j] at bits j*CNT_WIDTH
//  cumulative_unpacked  in   (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  inclusive cum[j]; M = cum[SYM_COUNT-1]
//  in                   in   SYM_WIDTH                symbol to encode
//  in_last              in   1                        qualifies in: final symbol of stream
//  in_vld / in_rdy      in/out 1                      input 4-phase handshake
//  out                  out  SYM_WIDTH                emitted nibble
//  out_vld / out_rdy    out/in 1                      output 4-phase handshake
//  done                 out  1                        1-cycle pulse after last flush nibble taken
//  err                  out  1                        1-cycle pulse: symbol with f=0 rejected
// BEHAVIOUR
//  Reset: in_rdy=1, out_vld=0, out=0, done=0, err=0, x=0, fresh=1, FSM=IDLE, divider cleared. Reset wins any cycle.
//  4-phase in: capture on in_vld&in_rdy, drop in_rdy next cycle; re-raise only in IDLE once in_vld seen low.
//  4-phase out: out/out_vld set together, held stable until out_rdy=1; then out_vld<=0; next nibble only
//   after out_rdy seen low. Same protocol as ans_decoder's in side.
//  Symbol latch: s, f=f[s], c=(s==0)?0:cum[s-1], last=in_last. If fresh: x<=M, fresh<=0.
//  FSM:
//   IDLE   : wait capture. f==0 -> err pulse, symbol dropped, x unchanged, stay IDLE (in_last ignored).
//            else -> RENORM.
//   RENORM : if x >= (f<<SYM_WIDTH): emit x[SYM_WIDTH-1:0] (4-phase), then x<=x>>SYM_WIDTH, re-test.
//            else -> DIV.
//   DIV    : restoring divider x/f, one quotient bit/cycle, STATE_WIDTH cycles -> q, r.
//   UPDATE : x <= q*M + c + r (STATE_WIDTH bits; fits given interval [M,M<<SYM_WIDTH)). last ? FLUSH : IDLE.
//   FLUSH  : emit STATE_WIDTH/SYM_WIDTH nibbles of x, LSB first, counter 0..N-1.
//   DONE   : done pulse 1 cycle; fresh<=1, x<=0 -> IDLE.
//  Invariant: after UPDATE, M <= x < M<<SYM_WIDTH. counts/cumulative must be static across a stream.
//  Latency (no back-pressure, no renorm): capture -> UPDATE = STATE_WIDTH+3 cycles.
//  ena=0 mid-handshake: outputs held; handshake resumes unchanged.
//  in_vld held high after capture: no second capture until it drops (no duplicate symbols).
//  in_last with f=0: err, stream not flushed; host must resend valid last symbol.
// TESTING
//  T1 all f=16 (M=256), encode {3,last} -> nibbles 0,0,3,1,0 then done; reversed 0,1,3,0,0 decodes to 3.
//  T2 f[5]=0, send 5 -> err pulse, no out_vld, x unchanged; next valid symbol encodes normally.
//  T3 T1 with out_rdy low 10 cycles per nibble -> out_vld and out held stable, no nibble lost/duplicated.
//  T4 assert rst during DIV -> next cycle in_rdy=1, out_vld=0, done=0; new stream matches T1 exactly.
//  T5 ena=0 for 5 cycles mid-RENORM and mid-FLUSH -> no state change; final stream identical to T1.
//  T6 random skewed table, 64 random symbols -> reversed stream through ans_decoder reproduces input.

Source files
------------

// File: rtl/ans_encoder.sv
// rANS encoder: 4-phase symbol input, renormalising nibble output, sequential
// restoring divider for x/f, and a final state flush when in_last is seen.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef SYM_COUNT
`define SYM_COUNT 16
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module ans_encoder #(
    parameter int unsigned SYM_WIDTH   = `SYM_WIDTH,
    parameter int unsigned SYM_COUNT   = `SYM_COUNT,
    parameter int unsigned CNT_WIDTH   = `CNT_WIDTH,
    parameter int unsigned STATE_WIDTH = `STATE_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      ena,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
    input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
    input  logic [SYM_WIDTH-1:0]                       in,
    input  logic                                      in_last,
    input  logic                                      in_vld,
    output logic                                      in_rdy,
    output logic [SYM_WIDTH-1:0]                       out,
    output logic                                      out_vld,
    input  logic                                      out_rdy,
    output logic                                      done,
    output logic                                      err
);
    localparam int unsigned MW  = CNT_WIDTH + SYM_WIDTH;
    localparam int unsigned NIB = STATE_WIDTH / SYM_WIDTH;
    localparam int unsigned CW  = $clog2(STATE_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, RENORM, DIV, UPDATE, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [STATE_WIDTH-1:0] x_q, x_d;
    logic                   fresh_q, fresh_d;
    logic [CNT_WIDTH-1:0]   f_q, f_d;
    logic [MW-1:0]          c_q, c_d;
    logic                   last_q, last_d;
    logic [STATE_WIDTH-1:0] quo_q, quo_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   in_rdy_q, in_rdy_d;
    logic [SYM_WIDTH-1:0]   out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic                   out_ack_q, out_ack_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [CNT_WIDTH-1:0]   f_tab   [SYM_COUNT];
    logic [MW-1:0]          cum_tab [SYM_COUNT];
    logic [MW-1:0]          m;
    logic [CNT_WIDTH-1:0]   f_in;
    logic [MW-1:0]          c_in;
    logic [CNT_WIDTH:0]     trial;
    logic                   take;
    logic [CNT_WIDTH-1:0]   diff;
    logic                   renorm_hi;
    logic                   out_free;
    logic                   capture;

    always_comb begin
        for (int unsigned j = 0; j < SYM_COUNT; j++) begin
            f_tab[j]   = counts_unpacked[j*CNT_WIDTH +: CNT_WIDTH];
            cum_tab[j] = cumulative_unpacked[j*MW +: MW];
        end
    end

    assign m    = cum_tab[SYM_COUNT-1];
    assign f_in = f_tab[in];
    assign c_in = (in == '0) ? '0 : cum_tab[in - 1'b1];

    // Restoring division step; diff only needs the low bits since it is used when trial >= f.
    assign trial = {rem_q, quo_q[STATE_WIDTH-1]};
    assign take  = (trial >= {1'b0, f_q});
    assign diff  = trial[CNT_WIDTH-1:0] - f_q;

    assign renorm_hi = (x_q >= STATE_WIDTH'({f_q, {SYM_WIDTH{1'b0}}}));
    assign out_free  = !out_vld_q && !out_ack_q;
    assign capture   = in_vld && in_rdy_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        fresh_d   = fresh_q;
        f_d       = f_q;
        c_d       = c_q;
        last_d    = last_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        in_rdy_d  = in_rdy_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        out_ack_d = out_ack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
            out_ack_d = 1'b1;
        end else if (out_ack_q && !out_rdy) begin
            out_ack_d = 1'b0;
        end

        if (state_q == IDLE && !in_rdy_q && !in_vld) begin
            in_rdy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    in_rdy_d = 1'b0;
                    if (f_in == '0) begin
                        err_d = 1'b1;
                    end else begin
                        f_d    = f_in;
                        c_d    = c_in;
                        last_d = in_last;
                        if (fresh_q) begin
                            x_d     = STATE_WIDTH'(m);
                            fresh_d = 1'b0;
                        end
                        state_d = RENORM;
                    end
                end
            end
            RENORM: begin
                // x is shifted at launch, so the re-test can proceed while the nibble is still pending.
                if (renorm_hi) begin
                    if (out_free) begin
                        out_d     = x_q[SYM_WIDTH-1:0];
                        out_vld_d = 1'b1;
                        x_d       = x_q >> SYM_WIDTH;
                    end
                end else begin
                    quo_d   = x_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = {quo_q[STATE_WIDTH-2:0], take};
                rem_d = take ? diff : trial[CNT_WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STATE_WIDTH - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                x_d     = quo_q * STATE_WIDTH'(m) + STATE_WIDTH'(c_q) + STATE_WIDTH'(rem_q);
                cnt_d   = '0;
                state_d = last_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (cnt_q == CW'(NIB)) begin
                    if (!out_vld_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else if (out_free) begin
                    out_d     = x_q[SYM_WIDTH-1:0];
                    out_vld_d = 1'b1;
                    x_d       = x_q >> SYM_WIDTH;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            DONE: begin
                fresh_d = 1'b1;
                x_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            fresh_q   <= 1'b1;
            f_q       <= '0;
            c_q       <= '0;
            last_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            out_ack_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            x_q       <= x_d;
            fresh_q   <= fresh_d;
            f_q       <= f_d;
            c_q       <= c_d;
            last_q    <= last_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            out_ack_q <= out_ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_ans_encoder.sv
// Directed bench for ans_encoder: hand-computed nibble streams for small tables,
// with back-pressure, reset, enable-freeze and handshake corner cases.
`timescale 1ns/1ps
module tb_ans_encoder;
    logic         clk;
    logic         rst;
    logic         ena;
    logic [127:0] counts_unpacked;
    logic [191:0] cumulative_unpacked;
    logic [3:0]   in;
    logic         in_last;
    logic         in_vld;
    logic         in_rdy;
    logic [3:0]   out;
    logic         out_vld;
    logic         out_rdy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ftab [16];
    logic [3:0] rx_q [$];
    int         rx_delay    = 0;
    bit         rx_en       = 1'b1;
    int         rx_wait     = 0;
    logic [3:0] rx_held     = '0;
    int         rx_unstable = 0;
    int         done_cnt    = 0;
    int         err_cnt     = 0;

    ans_encoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .counts_unpacked     (counts_unpacked),
        .cumulative_unpacked (cumulative_unpacked),
        .in                  (in),
        .in_last             (in_last),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .out                 (out),
        .out_vld             (out_vld),
        .out_rdy             (out_rdy),
        .done                (done),
        .err                 (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Host side of the output handshake: accepts each nibble after rx_delay cycles.
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (rx_en) begin
                if (out_vld && !out_rdy) begin
                    if (rx_wait == 0) rx_held = out;
                    else if (out !== rx_held) rx_unstable++;
                    if (rx_wait >= rx_delay) begin
                        rx_q.push_back(out);
                        out_rdy = 1'b1;
                        rx_wait = 0;
                    end else begin
                        rx_wait++;
                    end
                end else if (out_rdy && !out_vld) begin
                    out_rdy = 1'b0;
                end
            end
        end
    end

    // Received stream as {count, nibbles in arrival order, first nibble most significant}.
    function automatic logic [27:0] rx_word();
        logic [27:0] w;
        w = '0;
        foreach (rx_q[i]) w[23:0] = {w[19:0], rx_q[i]};
        w[27:24] = 4'(rx_q.size());
        return w;
    endfunction

    task automatic load_table();
        logic [11:0] acc;
        acc = '0;
        for (int j = 0; j < 16; j++) begin
            acc = acc + 12'(ftab[j]);
            counts_unpacked[j*8 +: 8]      = ftab[j];
            cumulative_unpacked[j*12 +: 12] = acc;
        end
    endtask

    task automatic send_sym(input logic [3:0] s, input logic l, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!in_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) return;
        in      = s;
        in_last = l;
        in_vld  = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_rdy && n < 300);
        in_vld = 1'b0;
        ok     = !in_rdy;
    endtask

    task automatic wait_done(input int target, input int limit, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ena     = 1'b1;
        in      = '0;
        in_last = 1'b0;
        in_vld  = 1'b0;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        repeat (3) @(negedge clk);
        checks++; if (in_rdy !== 1'b1)  begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++; if (out !== 4'h0)     begin errors++; $display("FAIL reset_out got %h want 0", out); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        rx_delay = 0;
        rx_q.delete();
        d0 = done_cnt;
        send_sym(4'd3, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_capture got %b want 1", ok); end
        wait_done(d0 + 1, 500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_done_timeout got %b want 1", ok); end
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h5000310) begin errors++; $display("FAIL t1_stream got %h want 5000310", rx_word()); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t1_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL t1_in_rdy_back got %b want 1", in_rdy); end
    endtask

    task automatic test_reject();
        bit ok;
        int d0;
        int e0;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        ftab[5] = 8'd0;
        load_table();
        rx_delay = 0;
        rx_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        send_sym(4'd5, 1'b1, ok);
        repeat (30) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL t2_err_pulses got %0d want 1", err_cnt - e0); end
        checks++; if (rx_q.size() !== 0)  begin errors++; $display("FAIL t2_no_output got %0d want 0", rx_q.size()); end
        checks++; if (done_cnt !== d0)    begin errors++; $display("FAIL t2_no_flush got %0d want %0d", done_cnt, d0); end
        checks++; if (in_rdy !== 1'b1)    begin errors++; $display("FAIL t2_in_rdy got %b want 1", in_rdy); end
        send_sym(4'd3, 1'b1, ok);
        wait_done(d0 + 1, 500, ok);
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h40004E0) begin errors++; $display("FAIL t2_stream got %h want 40004e0", rx_word()); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL t2_err_total got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int d0;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        rx_delay    = 10;
        rx_unstable = 0;
        rx_q.delete();
        d0 = done_cnt;
        send_sym(4'd3, 1'b1, ok);
        wait_done(d0 + 1, 1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t3_done_timeout got %b want 1", ok); end
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h5000310) begin errors++; $display("FAIL t3_stream got %h want 5000310", rx_word()); end
        checks++; if (rx_unstable !== 0) begin errors++; $display("FAIL t3_out_stable got %0d changes want 0", rx_unstable); end
        rx_delay = 0;
    endtask

    task automatic test_reset_mid_div();
        bit ok;
        int d0;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        rx_delay = 0;
        rx_q.delete();
        send_sym(4'd3, 1'b1, ok);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1)  begin errors++; $display("FAIL t4_in_rdy got %b want 1", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL t4_out_vld got %b want 0", out_vld); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL t4_done got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
        rx_wait = 0;
        rx_q.delete();
        d0 = done_cnt;
        send_sym(4'd3, 1'b1, ok);
        wait_done(d0 + 1, 500, ok);
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h5000310) begin errors++; $display("FAIL t4_stream got %h want 5000310", rx_word()); end
    endtask

    task automatic test_ena_freeze();
        bit         ok;
        int         d0;
        int         n;
        logic [3:0] held;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        rx_delay    = 3;
        rx_unstable = 0;
        rx_q.delete();
        d0 = done_cnt;
        send_sym(4'd3, 1'b1, ok);
        n = 0;
        while (!out_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL t5_renorm_vld got %b want 1", out_vld); end
        ena   = 1'b0;
        rx_en = 1'b0;
        held  = out;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out !== held) begin
                errors++; $display("FAIL t5_freeze_renorm got vld=%b out=%h want vld=1 out=%h", out_vld, out, held);
            end
        end
        ena   = 1'b1;
        rx_en = 1'b1;
        n = 0;
        while (!(rx_q.size() >= 3 && out_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL t5_flush_vld got %b want 1", out_vld); end
        ena   = 1'b0;
        rx_en = 1'b0;
        held  = out;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out !== held || in_rdy !== 1'b0) begin
                errors++; $display("FAIL t5_freeze_flush got vld=%b out=%h rdy=%b want vld=1 out=%h rdy=0", out_vld, out, in_rdy, held);
            end
        end
        ena   = 1'b1;
        rx_en = 1'b1;
        wait_done(d0 + 1, 1000, ok);
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h5000310) begin errors++; $display("FAIL t5_stream got %h want 5000310", rx_word()); end
        checks++; if (rx_unstable !== 0) begin errors++; $display("FAIL t5_out_stable got %0d changes want 0", rx_unstable); end
        rx_delay = 0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit all_ok;
        int d0;
        logic [3:0] syms [4];
        syms[0] = 4'd0; syms[1] = 4'd1; syms[2] = 4'd2; syms[3] = 4'd3;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd0;
        ftab[0] = 8'd7; ftab[1] = 8'd5; ftab[2] = 8'd3; ftab[3] = 8'd1;
        load_table();
        rx_delay = 1;
        rx_q.delete();
        d0     = done_cnt;
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_sym(syms[k], (k == 3), ok);
            all_ok = all_ok & ok;
        end
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL t6_captures got %b want 1", all_ok); end
        wait_done(d0 + 1, 1000, ok);
        repeat (4) @(negedge clk);
        checks++; if (rx_word() !== 28'h6BCF200) begin errors++; $display("FAIL t6_stream got %h want 6bcf200", rx_word()); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t6_done_pulses got %0d want 1", done_cnt - d0); end
        rx_delay = 0;
    endtask

    task automatic test_hold_vld();
        bit ok;
        int d0;
        int n;
        for (int j = 0; j < 16; j++) ftab[j] = 8'd16;
        load_table();
        rx_delay = 0;
        rx_q.delete();
        d0 = done_cnt;
        n  = 0;
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        in      = 4'd3;
        in_last = 1'b1;
        in_vld  = 1'b1;
        wait_done(d0 + 1, 500, ok);
        repeat (8) @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL hold_no_rerdy got %b want 0", in_rdy); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL hold_single_stream got %0d want 1", done_cnt - d0); end
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL hold_rerdy got %b want 1", in_rdy); end
        checks++; if (rx_word() !== 28'h5000310) begin errors++; $display("FAIL hold_stream got %h want 5000310", rx_word()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_reject();
        test_backpressure();
        test_reset_mid_div();
        test_ena_freeze();
        test_back_to_back();
        test_hold_vld();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
